y86_bus_tracer: RTL and testbench

- Passive monitor that sits directly downstream of the y86 sequential core's memory bus.
- Every cycle the core asserts bus_RE or bus_WE, it captures one record: address, data, direction, opcode and timestamp.
- Records are buffered in a FIFO and drained by a valid/ready consumer (fault-analysis logger or testbench scoreboard).
- Never drives the core's bus; adds no load to its timing.

---
 rtl/y86_trace_pkg.sv | 31 +++
 rtl/y86_trace_fifo.sv | 79 +++++++
 rtl/y86_bus_tracer.sv | 133 +++++++++++++
 tb/tb_y86_bus_tracer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_trace_pkg.sv
// -----------------------------------------------------------------------------
// y86_trace_pkg
// Shared definitions for the y86 memory-bus tracer: the trace record layout,
// read/write direction encodings and default sizing parameters.
// -----------------------------------------------------------------------------
package y86_trace_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_DROP_W = 16;

  // Direction encoding carried in the record's wr bit
  localparam logic REC_RD = 1'b0;
  localparam logic REC_WR = 1'b1;

  // Record layout at the default timestamp width; the top packs records in
  // the same field order so this struct can overlay a FIFO word directly.
  typedef struct packed {
    logic [31:0]         addr;
    logic [31:0]         data;
    logic                wr;
    logic [7:0]          opcode;
    logic [DEF_TS_W-1:0] ts;
  } trace_rec_t;

  // Packed record width for a given timestamp width
  function automatic int rec_width(input int ts_w);
    return 32 + 32 + 1 + 8 + ts_w;
  endfunction

endpackage

// File: rtl/y86_trace_fifo.sv
// -----------------------------------------------------------------------------
// y86_trace_fifo
// Single-clock synchronous FIFO. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored, so a push and
// a pop into an empty FIFO simply enqueue.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  enqueue request and word
//   pop          dequeue request (gated internally by !empty)
//   rdata        head word (valid when !empty)
//   full, empty  occupancy flags derived from the level count
//   level        current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module y86_trace_fifo #(
  parameter int WIDTH = 89,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign do_pop_s  = pop && !empty;
  // Full FIFO still takes a word when the head leaves in the same cycle
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array; cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write indices (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/y86_bus_tracer.sv
// -----------------------------------------------------------------------------
// y86_bus_tracer
// Passive monitor on the y86 core memory bus. Each cycle with trace_en and a
// read or write strobe captures {addr, data, wr, opcode, ts} into a FIFO that
// a valid/ready consumer drains. Records arriving while the FIFO is full and
// not being popped are counted in a saturating drop counter.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   trace_en                   capture enable (FIFO drains regardless)
//   bus_A/bus_in/bus_out       core address, read data, write data
//   bus_RE/bus_WE              core read/write strobes
//   current_opcode             opcode held in core IR
//   rec_valid/rec_ready        head-record handshake
//   rec_addr..rec_ts           head-record payload
//   level                      FIFO occupancy
//   drop_cnt                   saturating count of dropped records
//   overflow, proto_err        sticky error flags
// -----------------------------------------------------------------------------
module y86_bus_tracer
  import y86_trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TS_W   = DEF_TS_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic [31:0]              bus_A,
  input  logic [31:0]              bus_in,
  input  logic [31:0]              bus_out,
  input  logic                     bus_RE,
  input  logic                     bus_WE,
  input  logic [7:0]               current_opcode,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [31:0]              rec_addr,
  output logic [31:0]              rec_data,
  output logic                     rec_wr,
  output logic [7:0]               rec_opcode,
  output logic [TS_W-1:0]          rec_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     overflow,
  output logic                     proto_err
);

  localparam int REC_W = rec_width(TS_W);

  logic [TS_W-1:0]   ts_r;
  logic [DROP_W-1:0] drop_cnt_r;
  logic              overflow_r;
  logic              proto_err_r;

  logic              capture_s;
  logic              wr_s;
  logic [31:0]       cap_data_s;
  logic [REC_W-1:0]  push_rec_s;
  logic [REC_W-1:0]  head_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              drop_s;

  assign capture_s = trace_en && (bus_RE || bus_WE);
  // A write strobe wins when both strobes are high
  assign wr_s      = bus_WE ? REC_WR : REC_RD;
  assign pop_s     = rec_ready && !empty_s;
  assign drop_s    = capture_s && full_s && !pop_s;

  // Record data follows the bus direction
  always_comb begin
    cap_data_s = bus_in;
    if (bus_WE) begin
      cap_data_s = bus_out;
    end else begin
      cap_data_s = bus_in;
    end
  end

  assign push_rec_s = {bus_A, cap_data_s, wr_s, current_opcode, ts_r};

  y86_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture_s),
    .wdata (push_rec_s),
    .pop   (rec_ready),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

  assign rec_valid = !empty_s;
  assign {rec_addr, rec_data, rec_wr, rec_opcode, rec_ts} = head_s;

  // Free-running timestamp; records take the pre-increment value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Saturating drop counter and sticky overflow / protocol-error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r  <= {DROP_W{1'b0}};
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {DROP_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + DROP_W'(1);
        end
      end
      if (bus_RE && bus_WE) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign drop_cnt  = drop_cnt_r;
  assign overflow  = overflow_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_y86_bus_tracer.sv
// -----------------------------------------------------------------------------
// tb_y86_bus_tracer
// Directed bench for y86_bus_tracer with DEPTH=16. Inputs change on the
// falling edge; outputs are sampled on the falling edge, half a period away
// from the capturing rising edge.
// -----------------------------------------------------------------------------
module tb_y86_bus_tracer;

  logic        clk;
  logic        rst_n;
  logic        trace_en;
  logic [31:0] bus_A;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_RE;
  logic        bus_WE;
  logic [7:0]  current_opcode;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic        rec_wr;
  logic [7:0]  rec_opcode;
  logic [15:0] rec_ts;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        proto_err;

  int          n_cmp;
  int          n_err;
  logic [15:0] tb_ts;
  logic [15:0] ts0;

  y86_bus_tracer #(
    .DEPTH  (16),
    .TS_W   (16),
    .DROP_W (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_en       (trace_en),
    .bus_A          (bus_A),
    .bus_in         (bus_in),
    .bus_out        (bus_out),
    .bus_RE         (bus_RE),
    .bus_WE         (bus_WE),
    .current_opcode (current_opcode),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_addr       (rec_addr),
    .rec_data       (rec_data),
    .rec_wr         (rec_wr),
    .rec_opcode     (rec_opcode),
    .rec_ts         (rec_ts),
    .level          (level),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: number of rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts = 16'd0;
    else        tb_ts = tb_ts + 16'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bus cycle for one rising edge, then return the strobes to idle
  task automatic bus_cyc(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] din, input logic [31:0] dout,
                         input logic [7:0] op);
    bus_RE = re; bus_WE = we; bus_A = a; bus_in = din; bus_out = dout;
    current_opcode = op;
    @(negedge clk);
    bus_RE = 1'b0; bus_WE = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; trace_en = 1'b0; rec_ready = 1'b0;
    bus_A = 32'h0; bus_in = 32'h0; bus_out = 32'h0;
    bus_RE = 1'b0; bus_WE = 1'b0; current_opcode = 8'h0;
    #12;
    check("rst_valid",    64'(rec_valid), 64'h0);
    check("rst_level",    64'(level),     64'h0);
    check("rst_drop",     64'(drop_cnt),  64'h0);
    check("rst_overflow", 64'(overflow),  64'h0);
    check("rst_proto",    64'(proto_err), 64'h0);
    check("rst_addr",     64'(rec_addr),  64'h0);
    check("rst_ts",       64'(rec_ts),    64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    trace_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single read at timestamp 5
    bus_cyc(1'b1, 1'b0, 32'h0, 32'h0000C389, 32'h0, 8'h89);
    check("rd_valid",  64'(rec_valid),  64'h1);
    check("rd_addr",   64'(rec_addr),   64'h0);
    check("rd_data",   64'(rec_data),   64'h0000C389);
    check("rd_wr",     64'(rec_wr),     64'h0);
    check("rd_opcode", 64'(rec_opcode), 64'h89);
    check("rd_ts",     64'(rec_ts),     64'd5);
    check("rd_level",  64'(level),      64'd1);

    // Drain it
    rec_ready = 1'b1;
    @(negedge clk);
    check("drain_level", 64'(level),     64'd0);
    check("drain_valid", 64'(rec_valid), 64'h0);

    // Write into an empty FIFO with ready high: pushed, not popped
    bus_cyc(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 8'h40);
    check("wr_valid", 64'(rec_valid), 64'h1);
    check("wr_level", 64'(level),     64'd1);
    check("wr_addr",  64'(rec_addr),  64'h40);
    check("wr_wr",    64'(rec_wr),    64'h1);
    check("wr_data",  64'(rec_data),  64'hDEADBEEF);
    @(negedge clk);
    check("wr_pop_level", 64'(level),     64'd0);
    check("wr_pop_valid", 64'(rec_valid), 64'h0);

    // 20 back-to-back reads with the consumer stalled
    rec_ready = 1'b0;
    ts0 = tb_ts;
    for (int i = 0; i < 20; i++) begin
      bus_cyc(1'b1, 1'b0, 32'(i * 4), 32'h1000 + 32'(i), 32'h0, 8'(i));
    end
    check("full_level",    64'(level),    64'd16);
    check("full_drop",     64'(drop_cnt), 64'd4);
    check("full_overflow", 64'(overflow), 64'h1);
    check("full_hold_addr", 64'(rec_addr), 64'h0);
    check("full_hold_ts",   64'(rec_ts),   64'(ts0));

    // Full FIFO: capture with simultaneous pop is accepted
    rec_ready = 1'b1;
    bus_cyc(1'b1, 1'b0, 32'hABC, 32'h5555, 32'h0, 8'h50);
    check("fullpop_level", 64'(level),    64'd16);
    check("fullpop_drop",  64'(drop_cnt), 64'd4);

    // Drain: records 1..15 in order, then the tail record
    for (int i = 1; i < 16; i++) begin
      check("drain_addr", 64'(rec_addr), 64'(i * 4));
      check("drain_data", 64'(rec_data), 64'h1000 + 64'(i));
      check("drain_ts",   64'(rec_ts),   64'(16'(ts0 + 16'(i))));
      @(negedge clk);
    end
    check("tail_addr", 64'(rec_addr), 64'hABC);
    check("tail_data", 64'(rec_data), 64'h5555);
    @(negedge clk);
    check("empty_level", 64'(level),     64'd0);
    check("empty_valid", 64'(rec_valid), 64'h0);
    rec_ready = 1'b0;

    // Both strobes high: protocol error, recorded as a write
    bus_cyc(1'b1, 1'b1, 32'h80, 32'h22, 32'h11, 8'h30);
    check("proto_err",  64'(proto_err), 64'h1);
    check("proto_wr",   64'(rec_wr),    64'h1);
    check("proto_data", 64'(rec_data),  64'h11);
    repeat (3) @(negedge clk);
    check("proto_sticky", 64'(proto_err), 64'h1);

    // Two more records -> three queued, then disable tracing
    bus_cyc(1'b1, 1'b0, 32'h84, 32'h1, 32'h0, 8'h31);
    bus_cyc(1'b0, 1'b1, 32'h88, 32'h0, 32'h2, 8'h32);
    check("q3_level", 64'(level), 64'd3);
    trace_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_cyc(1'b1, 1'b0, 32'h100, 32'h9, 32'h0, 8'h33);
    end
    check("dis_level", 64'(level),    64'd3);
    check("dis_head",  64'(rec_addr), 64'h80);

    // Mid-cycle asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",    64'(rec_valid), 64'h0);
    check("arst_level",    64'(level),     64'h0);
    check("arst_drop",     64'(drop_cnt),  64'h0);
    check("arst_overflow", 64'(overflow),  64'h0);
    check("arst_proto",    64'(proto_err), 64'h0);
    check("arst_addr",     64'(rec_addr),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
